// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcode/state encodings and instruction field offsets for reg_alu_core
package reg_alu_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_LDI = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11} opcode_e;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_e;
   // instr = {opcode, dest, src_a, src_b}; src_b sits at bit 0
   function automatic int src_a_lsb(input int aw);
      return aw;
   endfunction
   function automatic int dest_lsb(input int aw);
      return 2 * aw;
   endfunction
   function automatic int op_lsb(input int aw);
      return 3 * aw;
   endfunction
endpackage

// File: rtl/seq_shift_mul.sv
// seq_shift_mul: iterative shift-add multiplier, one partial product per cycle, done after DATA_W cycles
module seq_shift_mul #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   localparam int CW = $clog2(DATA_W + 1);
   logic [2*DATA_W-1:0] mcand;
   logic [DATA_W-1:0]   mplier;
   logic [CW-1:0]       cnt;
   always_ff @(posedge clk) begin
      if (clear) begin
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
         product <= '0;
         done <= 1'b0;
      end else if (start) begin
         mcand <= {{DATA_W{1'b0}}, a};
         mplier <= b;
         cnt <= CW'(DATA_W);
         product <= '0;
         done <= 1'b0;
      end else begin
         done <= cnt == CW'(1);
         if (cnt != '0) begin
            product <= mplier[0] ? product + mcand : product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: rtl/reg_alu_core.sv
// reg_alu_core: register-file ALU (ADD/SUB/LDI/MUL) with FSM writeback.
// Define REG_ALU_CORE_DBG_PORT_EN to add the dbg_addr/dbg_data register observation port.
module reg_alu_core
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 4,
   localparam int REG_AW = $clog2(NUM_REGS),
   localparam int INSTR_W = 2 + 3 * REG_AW
) (
   input  logic               clk,
   input  logic               clear,
`ifdef REG_ALU_CORE_DBG_PORT_EN
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data,
`endif
   input  logic [INSTR_W-1:0] instr,
   input  logic [DATA_W-1:0]  imm_in,
   input  logic               carry_in,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic               busy,
   output logic               result_valid,
   output logic [REG_AW-1:0]  result_dest,
   output logic [DATA_W-1:0]  result_data,
   output logic               carry_flag
);
   localparam int SA = src_a_lsb(REG_AW);
   localparam int DL = dest_lsb(REG_AW);
   localparam int OL = op_lsb(REG_AW);
   state_e state, state_n;
   opcode_e op, op_in;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] a_in, b_in, a_q, b_q, imm_q, res_q, wdata;
   logic [REG_AW-1:0] dest_q;
   logic [DATA_W:0] sum;
   logic [2*DATA_W-1:0] product;
   logic cin_q, c_q, wc, accept, mul_done;
   assign op_in = opcode_e'(instr[OL +: 2]);
   assign a_in = regs[instr[SA +: REG_AW]];
   assign b_in = regs[instr[REG_AW-1:0]];
   assign instr_ready = state == S_IDLE;
   assign busy = !instr_ready;
   assign accept = instr_valid && instr_ready;
`ifdef REG_ALU_CORE_DBG_PORT_EN
   assign dbg_data = regs[dbg_addr];
`endif
   seq_shift_mul #(.DATA_W(DATA_W)) u_mul (
      .clk(clk),
      .clear(clear),
      .start(accept && op_in == OP_MUL),
      .a(a_in),
      .b(b_in),
      .done(mul_done),
      .product(product)
   );
   always_ff @(posedge clk) state <= clear ? S_IDLE : state_n;
   always_comb begin
      state_n = state;
      state_n = state == S_IDLE ? (accept ? (op_in == OP_MUL ? S_MUL : S_EXEC) : S_IDLE)
              : state == S_EXEC ? S_WB
              : state == S_MUL ? (mul_done ? S_WB : S_MUL)
              : S_IDLE;
   end
   // SUB reuses the adder as A + ~B + 1
   always_comb begin
      sum = {1'b0, a_q} + {1'b0, op == OP_SUB ? ~b_q : b_q} + {{DATA_W{1'b0}}, op == OP_SUB ? 1'b1 : cin_q};
      wdata = op == OP_MUL ? product[DATA_W-1:0] : res_q;
      wc = op == OP_MUL ? |product[2*DATA_W-1:DATA_W] : c_q;
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         op <= op_in;
         dest_q <= instr[DL +: REG_AW];
         a_q <= a_in;
         b_q <= b_in;
         imm_q <= imm_in;
         cin_q <= carry_in;
      end
      if (state == S_EXEC) begin
         res_q <= op == OP_LDI ? imm_q : sum[DATA_W-1:0];
         c_q <= op == OP_LDI ? carry_flag : sum[DATA_W];
      end
   end
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         result_valid <= 1'b0;
         result_dest <= '0;
         result_data <= '0;
         carry_flag <= 1'b0;
      end else begin
         result_valid <= state == S_WB;
         if (state == S_WB) begin
            regs[dest_q] <= wdata;
            result_data <= wdata;
            result_dest <= dest_q;
            carry_flag <= wc;
         end
      end
   end
endmodule

// File: tb/tb_reg_alu_core.sv
// tb_reg_alu_core: scoreboard bench for reg_alu_core at defaults plus a 16-bit/8-register instance
module tb_reg_alu_core;
   logic clk = 1'b0, clear = 1'b1;
   logic [7:0] instr = '0, imm_in = '0, result_data;
   logic carry_in = 1'b0, instr_valid = 1'b0;
   logic instr_ready, busy, result_valid, carry_flag;
   logic [1:0] result_dest;
   logic [10:0] instr2 = '0;
   logic [15:0] imm2 = '0, rdata2;
   logic valid2 = 1'b0, ready2, busy2, rv2, cf2;
   logic [2:0] rdest2;
`ifdef REG_ALU_CORE_DBG_PORT_EN
   logic [1:0] dbg_addr = '0;
   logic [7:0] dbg_data;
   logic [2:0] dbg_addr2 = '0;
   logic [15:0] dbg_data2;
`endif
   int checks = 0, failures = 0, cyc = 0;
   int model [4];
   int model_c = 0;
   typedef struct {int dest; int data; int cf; int due;} exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   reg_alu_core dut (
      .clk(clk), .clear(clear),
`ifdef REG_ALU_CORE_DBG_PORT_EN
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
      .instr(instr), .imm_in(imm_in), .carry_in(carry_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy), .result_valid(result_valid),
      .result_dest(result_dest), .result_data(result_data), .carry_flag(carry_flag)
   );
   reg_alu_core #(.DATA_W(16), .NUM_REGS(8)) dut16 (
      .clk(clk), .clear(clear),
`ifdef REG_ALU_CORE_DBG_PORT_EN
      .dbg_addr(dbg_addr2), .dbg_data(dbg_data2),
`endif
      .instr(instr2), .imm_in(imm2), .carry_in(1'b0), .instr_valid(valid2),
      .instr_ready(ready2), .busy(busy2), .result_valid(rv2),
      .result_dest(rdest2), .result_data(rdata2), .carry_flag(cf2)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      if (result_valid) begin
         if (sb.size() == 0) check("spurious_wb", result_valid, 0);
         else begin
            e = sb.pop_front();
            check("wb_data", result_data, e.data);
            check("wb_dest", result_dest, e.dest);
            check("wb_carry", carry_flag, e.cf);
            check("wb_latency", cyc, e.due);
         end
      end
   end
   task automatic issue(input logic [1:0] op, input int d, input int a, input int b, input int imm, input bit cin, input bit track);
      int n, r, c, s;
      n = 0;
      while (!instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", instr_ready, 1);
      c = model_c;
      case (op)
         2'b00: begin s = model[a] + model[b] + int'(cin); r = s % 256; c = s / 256; end
         2'b01: r = imm;
         2'b10: begin s = model[a] + 256 - model[b]; r = s % 256; c = s / 256; end
         default: begin s = model[a] * model[b]; r = s % 256; c = int'(s / 256 != 0); end
      endcase
      if (track) begin
         model[d] = r;
         model_c = c;
         sb.push_back('{d, r, c, cyc + 1 + (op == 2'b11 ? 10 : 2)});
      end
      instr = {op, 2'(d), 2'(a), 2'(b)};
      imm_in = 8'(imm);
      carry_in = cin;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask
   task automatic run16(input logic [10:0] ins, input logic [15:0] imm, input logic [15:0] exp_d, input string tag);
      int n;
      n = 0;
      while (!ready2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      instr2 = ins;
      imm2 = imm;
      valid2 = 1'b1;
      @(negedge clk);
      valid2 = 1'b0;
      n = 0;
      while (!rv2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, rv2, 1);
      check({tag, "_data"}, rdata2, exp_d);
      check({tag, "_dest"}, rdest2, 7);
      check({tag, "_carry"}, cf2, 0);
   endtask
   initial begin
      for (int i = 0; i < 4; i++) model[i] = 0;
      repeat (3) @(negedge clk);
      clear = 1'b0;
      check("rst_ready", instr_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_dest", result_dest, 0);
      check("rst_data", result_data, 0);
      check("rst_carry", carry_flag, 0);
      issue(2'b01, 1, 0, 0, 8'h05, 1'b0, 1'b1);
      issue(2'b01, 2, 0, 0, 8'h03, 1'b0, 1'b1);
      issue(2'b00, 3, 1, 2, 0, 1'b1, 1'b1);
      issue(2'b01, 0, 0, 0, 8'hFF, 1'b0, 1'b1);
      issue(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
      issue(2'b10, 3, 2, 1, 0, 1'b0, 1'b1);
      issue(2'b10, 3, 1, 2, 0, 1'b0, 1'b1);
      issue(2'b11, 3, 1, 2, 0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check("mul_ready", instr_ready, 0);
         check("mul_busy", busy, 1);
         if (k == 2) begin
            instr = {2'b01, 2'd1, 2'd0, 2'd0};
            imm_in = 8'hAA;
            instr_valid = 1'b1;
         end
         if (k == 3) instr_valid = 1'b0;
         @(negedge clk);
      end
      drain();
      issue(2'b11, 0, 0, 0, 0, 1'b0, 1'b1);
      drain();
      issue(2'b11, 0, 1, 2, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 0;
      model_c = 0;
      check("clr_ready", instr_ready, 1);
      check("clr_busy", busy, 0);
      check("clr_carry", carry_flag, 0);
      check("clr_valid", result_valid, 0);
      repeat (14) @(negedge clk);
`ifdef REG_ALU_CORE_DBG_PORT_EN
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1 check("clr_dbg", dbg_data, 0);
      end
`endif
      for (int i = 0; i < 4; i++) issue(2'b00, i, i, i, 0, 1'b0, 1'b1);
      drain();
      run16({2'b01, 3'd7, 3'd0, 3'd0}, 16'h1234, 16'h1234, "w16_ldi");
      run16({2'b00, 3'd7, 3'd7, 3'd7}, 16'h0000, 16'h2468, "w16_add");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
